throw_turn_ctl: RTL and testbench
=================================

# throw_turn_ctl

Turn scheduler for the cat-vs-dog throwing game. Owns the shared throw button, alternates turns between the dog and cat throw controllers, and charges throw force from button hold time. It draws a pseudo-random wind value per turn, counts hits into hit points, and declares the winner. Sits between the button synchroniser and the two `throw_ctl_*` instances; its outputs also feed the HUD/draw logic.

## Interface
- `TICK_CYCLES`, 1300000: clocks per game tick (≈20 ms at 65 MHz).
- `FORCE_STEP`, 16: throw_force increment per tick while charging.
- `HP_INIT`, 3: starting hit points per player (1..15).
- `FLIGHT_TIMEOUT`, 250: ticks after which a throw is force-ended if `throw_done` never arrives.
- `LFSR_SEED`, 8'hA5: non-zero wind LFSR reset value.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_throw` in 1: throw button, already synchronised and debounced, level.
- `throw_done_dog` in 1: from the dog throw controller.
- `throw_done_cat` in 1: from the cat throw controller.
- `hit_by_dog` in 1: 1-cycle pulse, dog's projectile struck the cat.
- `hit_by_cat` in 1: 1-cycle pulse, cat's projectile struck the dog.
- `enable_dog` out 1: throw request to the dog controller.
- `enable_cat` out 1: throw request to the cat controller.
- `throw_force` out 10: force for the active throw.
- `wind_force` out 7: 0..100, 50 = calm.
- `hp_dog`, `hp_cat` out 4 each: remaining hit points.
- `turn` out 1: 0 = dog, 1 = cat.
- `charging` out 1: high in ST_CHARGE (HUD power bar).
- `game_over` out 1: high in ST_OVER.
- `winner` out 1: 0 = dog, 1 = cat; valid while `game_over` is high.

## Operation
- Tick generator: free-running counter, 0..TICK_CYCLES-1. `tick` pulses one cycle on wrap. Cleared by `rst`.
- Wind LFSR: 8 bits, taps x^8+x^6+x^5+x^4+1, shifts every clock. Candidate `c = lfsr[6:0]`. Wind is `c` if c ≤ 100, else c−64. Result is always 0..100.
- States:
  - ST_AIM: latch the new wind candidate on entry; clear `throw_force` to 0. Go to ST_CHARGE when `btn_throw` is 1.
  - ST_CHARGE: on each `tick`, `throw_force` += FORCE_STEP, saturating at 1023. Go to ST_FLIGHT when `btn_throw` is 0.
  - ST_FLIGHT: assert the enable of the player selected by `turn`; the other enable stays 0. Count ticks. Accept at most one hit, and only from the active player: `hit_by_dog` when turn=0, `hit_by_cat` when turn=1. A hit decrements the opponent's HP, saturating at 0. Exit to ST_RELEASE when the active `throw_done` is 1 or the tick count reaches FLIGHT_TIMEOUT.
  - ST_RELEASE: both enables 0. Wait until the active `throw_done` is 0, then go to ST_SCORE.
  - ST_SCORE, 1 cycle: if the opponent's HP is 0, set `winner`=`turn` and go to ST_OVER. Otherwise toggle `turn` and go to ST_AIM.
  - ST_OVER: `game_over`=1. A full `btn_throw` press then release restores both HP to HP_INIT, sets `turn`=0, clears `game_over`, and goes to ST_AIM.
- `throw_force` and `wind_force` are stable from ST_FLIGHT entry through ST_SCORE.
- Hit pulses from the inactive player, or outside ST_FLIGHT, are ignored.

## Timing
- Reset values:
  - enables 0
  - `throw_force` 0
  - `wind_force` 50
  - `hp_dog` = `hp_cat` = HP_INIT
  - `turn` 0
  - `charging` 0
  - `game_over` 0
  - `winner` 0
  - LFSR = LFSR_SEED
  - state ST_AIM
  - tick counter 0
- `rst` mid-game: all of the above on the next edge; enables drop in the same cycle.
- Enable rises on the first clock edge after `btn_throw` is sampled 0 in ST_CHARGE.
- Enable falls on the edge after `throw_done` is sampled 1, or after the timeout tick.
- Release-to-score latency: 1 cycle after `throw_done` is sampled 0. Score to ST_AIM: 1 cycle.
- Button released on the same edge it was pressed: one cycle in ST_CHARGE with no tick, so the throw has force 0. This is legal.
- Hit pulse and `throw_done` in the same cycle: the hit is counted.
- `tick` and the button release in the same cycle in ST_CHARGE: the increment is applied.
- HP already 0 is never decremented below 0.

## Test plan
- TICK_CYCLES=4, FORCE_STEP=16: hold `btn_throw` 40 clocks then release -> `throw_force`=160, `enable_dog`=1 one cycle later, `enable_cat`=0.
- Hold for 400 ticks -> `throw_force` saturates at 1023.
- Dog turn, pulse `hit_by_dog` twice, then `throw_done_dog` 1→0 -> `hp_cat` 3→2 (one hit only), `turn`=1, `wind_force` re-latched in 0..100.
- `hit_by_cat` pulse during a dog flight -> no HP change.
- FLIGHT_TIMEOUT=5, `throw_done` held 0 -> enable drops after 5 ticks, turn passes.
- Cat lands 3 hits on 3 turns -> `hp_dog`=0, `game_over`=1, `winner`=1. Press and release -> both HP=3, `turn`=0, `game_over`=0. Assert `rst` mid-flight -> enables 0 next cycle, all reset values restored.

Source files
------------

// File: rtl/throw_turn_ctl.sv
// throw_turn_ctl
//
// Turn scheduler for the cat-vs-dog throwing game. Owns the shared throw
// button, alternates turns between the dog and cat throw controllers,
// charges throw force from button hold time, draws a pseudo-random wind
// value per turn, tracks hit points and declares the winner.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   btn_throw         synchronised/debounced throw button (level)
//   throw_done_dog/cat  flight-finished level from each throw controller
//   hit_by_dog/cat    1-cycle hit pulses (dog hit cat / cat hit dog)
//   enable_dog/cat    throw request to each throw controller
//   throw_force       force of the active throw (0..1023)
//   wind_force        wind for this turn, 0..100, 50 = calm
//   hp_dog, hp_cat    remaining hit points
//   turn              0 = dog, 1 = cat
//   charging          high while the button is charging the throw
//   game_over         high once a player has no hit points left
//   winner            0 = dog, 1 = cat; valid while game_over is high
module throw_turn_ctl #(
    parameter int unsigned TICK_CYCLES    = 1300000,
    parameter int unsigned FORCE_STEP     = 16,
    parameter int unsigned HP_INIT        = 3,
    parameter int unsigned FLIGHT_TIMEOUT = 250,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_throw,
    input  logic       throw_done_dog,
    input  logic       throw_done_cat,
    input  logic       hit_by_dog,
    input  logic       hit_by_cat,
    output logic       enable_dog,
    output logic       enable_cat,
    output logic [9:0] throw_force,
    output logic [6:0] wind_force,
    output logic [3:0] hp_dog,
    output logic [3:0] hp_cat,
    output logic       turn,
    output logic       charging,
    output logic       game_over,
    output logic       winner
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int FLT_W  = $clog2(FLIGHT_TIMEOUT + 1);
    localparam logic [3:0] HP_START = 4'(HP_INIT);

    typedef enum logic [2:0] {
        ST_AIM,
        ST_CHARGE,
        ST_FLIGHT,
        ST_RELEASE,
        ST_SCORE,
        ST_OVER
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic [7:0]         lfsr;
    logic               lfsr_fb;
    logic [6:0]         wind_cand;
    logic [FLT_W-1:0]   flight_cnt;
    logic               flight_timeout;
    logic               hit_taken;
    logic               restart_armed;
    logic               active_done;
    logic               active_hit;
    logic [3:0]         opp_hp;

    // Add one force step, clamping at the 10-bit maximum.
    function automatic logic [9:0] force_sat_add(input logic [9:0] f);
        logic [10:0] sum;
        sum = {1'b0, f} + 11'(FORCE_STEP);
        return sum[10] ? 10'd1023 : sum[9:0];
    endfunction

    // Decrement hit points without wrapping below zero.
    function automatic logic [3:0] hp_sat_dec(input logic [3:0] hp);
        return (hp == 4'd0) ? 4'd0 : hp - 4'd1;
    endfunction

    // Fold LFSR candidates above 100 back into range; 101..127 -> 37..63.
    function automatic logic [6:0] wind_map(input logic [6:0] c);
        return (c > 7'd100) ? c - 7'd64 : c;
    endfunction

    assign tick        = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
    assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign wind_cand   = wind_map(lfsr[6:0]);

    // Only the player whose turn it is can finish a flight or score a hit.
    assign active_done = turn ? throw_done_cat : throw_done_dog;
    assign active_hit  = turn ? hit_by_cat : hit_by_dog;
    assign opp_hp      = turn ? hp_dog : hp_cat;

    // Timeout fires on the tick that would bring the count to FLIGHT_TIMEOUT.
    assign flight_timeout = tick && (flight_cnt == FLT_W'(FLIGHT_TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            ST_AIM:     if (btn_throw) state_next = ST_CHARGE;
            ST_CHARGE:  if (!btn_throw) state_next = ST_FLIGHT;
            ST_FLIGHT:  if (active_done || flight_timeout) state_next = ST_RELEASE;
            ST_RELEASE: if (!active_done) state_next = ST_SCORE;
            ST_SCORE:   state_next = (opp_hp == 4'd0) ? ST_OVER : ST_AIM;
            ST_OVER:    if (restart_armed && !btn_throw) state_next = ST_AIM;
            default:    state_next = ST_AIM;
        endcase
    end

    // Enables are gated by rst so they drop in the reset cycle itself.
    assign enable_dog = (state == ST_FLIGHT) && !turn && !rst;
    assign enable_cat = (state == ST_FLIGHT) &&  turn && !rst;
    assign charging   = (state == ST_CHARGE);
    assign game_over  = (state == ST_OVER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_AIM;
            tick_cnt      <= '0;
            lfsr          <= LFSR_SEED;
            throw_force   <= 10'd0;
            wind_force    <= 7'd50;
            hp_dog        <= HP_START;
            hp_cat        <= HP_START;
            turn          <= 1'b0;
            winner        <= 1'b0;
            flight_cnt    <= '0;
            hit_taken     <= 1'b0;
            restart_armed <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            lfsr     <= {lfsr[6:0], lfsr_fb};

            case (state)
                ST_AIM: throw_force <= 10'd0;
                ST_CHARGE: begin
                    if (tick) throw_force <= force_sat_add(throw_force);
                    // Fresh flight: restart tick count and hit acceptance.
                    if (!btn_throw) begin
                        flight_cnt <= '0;
                        hit_taken  <= 1'b0;
                    end
                end
                ST_FLIGHT: begin
                    if (tick) flight_cnt <= flight_cnt + 1'b1;
                    if (active_hit && !hit_taken) begin
                        hit_taken <= 1'b1;
                        if (turn) hp_dog <= hp_sat_dec(hp_dog);
                        else      hp_cat <= hp_sat_dec(hp_cat);
                    end
                end
                ST_SCORE: begin
                    if (opp_hp == 4'd0) begin
                        winner <= turn;
                    end else begin
                        turn       <= ~turn;
                        wind_force <= wind_cand;
                    end
                end
                ST_OVER: begin
                    // Restart needs a complete press followed by release.
                    if (btn_throw) begin
                        restart_armed <= 1'b1;
                    end else if (restart_armed) begin
                        restart_armed <= 1'b0;
                        hp_dog        <= HP_START;
                        hp_cat        <= HP_START;
                        turn          <= 1'b0;
                        wind_force    <= wind_cand;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_throw_turn_ctl.sv
module tb_throw_turn_ctl;

    localparam int TC  = 4;
    localparam int FS  = 16;
    localparam int HPI = 3;
    localparam int FTO = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_throw = 1'b0;
    logic       throw_done_dog = 1'b0;
    logic       throw_done_cat = 1'b0;
    logic       hit_by_dog = 1'b0;
    logic       hit_by_cat = 1'b0;
    logic       enable_dog, enable_cat;
    logic [9:0] throw_force;
    logic [6:0] wind_force;
    logic [3:0] hp_dog, hp_cat;
    logic       turn, charging, game_over, winner;

    always #5 clk = ~clk;

    throw_turn_ctl #(
        .TICK_CYCLES(TC), .FORCE_STEP(FS), .HP_INIT(HPI),
        .FLIGHT_TIMEOUT(FTO), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .btn_throw(btn_throw),
        .throw_done_dog(throw_done_dog), .throw_done_cat(throw_done_cat),
        .hit_by_dog(hit_by_dog), .hit_by_cat(hit_by_cat),
        .enable_dog(enable_dog), .enable_cat(enable_cat),
        .throw_force(throw_force), .wind_force(wind_force),
        .hp_dog(hp_dog), .hp_cat(hp_cat), .turn(turn),
        .charging(charging), .game_over(game_over), .winner(winner)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference tick counter and wind LFSR (x^8+x^6+x^5+x^4+1).
    logic [7:0] m_lfsr, m_lfsr_prev;
    int         m_tcnt;
    logic       m_tick_edge;
    always @(posedge clk) begin
        if (rst) begin
            m_lfsr <= 8'hA5;
            m_tcnt <= 0;
        end else begin
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_tcnt <= (m_tcnt == TC - 1) ? 0 : m_tcnt + 1;
        end
        m_lfsr_prev <= m_lfsr;
        m_tick_edge <= !rst && (m_tcnt == TC - 1);
    end

    function automatic int wind_of(input logic [7:0] l);
        int c;
        c = int'(l[6:0]);
        return (c > 100) ? c - 64 : c;
    endfunction

    typedef struct { int force_v; int player; bit timeout; } flight_t;
    typedef struct { int turn_v; int hpd; int hpc; int go; int win; } score_t;
    flight_t fq[$];
    score_t  sq[$];

    bit      mon_en = 1'b0;
    logic    en_prev, turn_prev, go_prev;
    int      flight_ticks;
    flight_t cur;
    bit      cur_valid = 1'b0;

    // Scoreboard monitor: flight entries pop on enable rise, score entries
    // pop whenever turn or game_over changes.
    always @(negedge clk) begin
        if (!mon_en) begin
            cur_valid = 1'b0;
        end else begin
            if (en_prev && m_tick_edge) flight_ticks++;
            if ((enable_dog | enable_cat) && !en_prev) begin
                flight_ticks = 0;
                if (fq.size() == 0) begin
                    check("flight_unexpected", 1, 0);
                end else begin
                    cur = fq.pop_front();
                    cur_valid = 1'b1;
                    check("force", throw_force, cur.force_v);
                    check("en_dog", enable_dog, cur.player == 0);
                    check("en_cat", enable_cat, cur.player == 1);
                end
            end
            if (!(enable_dog | enable_cat) && en_prev && cur_valid) begin
                if (cur.timeout) check("timeout_ticks", flight_ticks, FTO);
                check("force_hold", throw_force, cur.force_v);
                cur_valid = 1'b0;
            end
            if (turn !== turn_prev || game_over !== go_prev) begin
                if (sq.size() == 0) begin
                    check("score_unexpected", 1, 0);
                end else begin
                    score_t s;
                    s = sq.pop_front();
                    check("turn", turn, s.turn_v);
                    check("hp_dog", hp_dog, s.hpd);
                    check("hp_cat", hp_cat, s.hpc);
                    check("game_over", game_over, s.go);
                    if (s.win >= 0) check("winner", winner, s.win);
                    if (!game_over) check("wind", wind_force, wind_of(m_lfsr_prev));
                end
            end
        end
        en_prev   = enable_dog | enable_cat;
        turn_prev = turn;
        go_prev   = game_over;
    end

    int hpd_m = HPI;
    int hpc_m = HPI;
    int turn_m = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hit(input int who, input logic v);
        if (who == 1) hit_by_cat = v; else hit_by_dog = v;
    endtask

    task automatic set_done(input int who, input logic v);
        if (who == 1) throw_done_cat = v; else throw_done_dog = v;
    endtask

    // Press for 'hold' sampled cycles, then release. Counts ticks on every
    // edge spent in charge (including the release edge).
    task automatic throw_charge(input int hold, input bit to_exp);
        int ticks;
        int f;
        ticks = 0;
        btn_throw = 1'b1;
        step();
        check("charging", charging, 1);
        for (int i = 1; i < hold; i++) begin
            if (m_tcnt == TC - 1) ticks++;
            step();
        end
        btn_throw = 1'b0;
        if (m_tcnt == TC - 1) ticks++;
        f = ticks * FS;
        if (f > 1023) f = 1023;
        fq.push_back('{f, turn_m, to_exp});
        step();
    endtask

    task automatic push_score(input bit hit);
        if (hit) begin
            if (turn_m == 1) hpd_m = (hpd_m > 0) ? hpd_m - 1 : 0;
            else             hpc_m = (hpc_m > 0) ? hpc_m - 1 : 0;
        end
        if (((turn_m == 1) ? hpd_m : hpc_m) == 0) begin
            sq.push_back('{turn_m, hpd_m, hpc_m, 1, turn_m});
        end else begin
            turn_m ^= 1;
            sq.push_back('{turn_m, hpd_m, hpc_m, 0, -1});
        end
    endtask

    task automatic flight(input int good_hits, input int bad_hits, input bit hit_with_done,
                          input bit timeout);
        int who;
        int n;
        who = turn_m;
        for (int i = 0; i < bad_hits; i++) begin
            set_hit(1 - who, 1'b1); step(); set_hit(1 - who, 1'b0);
        end
        for (int i = 0; i < good_hits; i++) begin
            set_hit(who, 1'b1); step(); set_hit(who, 1'b0);
        end
        push_score((good_hits > 0) || hit_with_done);
        if (timeout) begin
            n = 0;
            while ((enable_dog | enable_cat) && n < 100) begin step(); n++; end
            if (n >= 100) check("timeout_bound", 0, 1);
        end else begin
            set_done(who, 1'b1);
            if (hit_with_done) set_hit(who, 1'b1);
            step();
            set_hit(who, 1'b0);
            step();
            set_done(who, 1'b0);
            step();
        end
        repeat (3) step();
    endtask

    task automatic check_reset_values();
        check("rst_en_dog", enable_dog, 0);
        check("rst_en_cat", enable_cat, 0);
        check("rst_force", throw_force, 0);
        check("rst_wind", wind_force, 50);
        check("rst_hp_dog", hp_dog, HPI);
        check("rst_hp_cat", hp_cat, HPI);
        check("rst_turn", turn, 0);
        check("rst_charging", charging, 0);
        check("rst_game_over", game_over, 0);
        check("rst_winner", winner, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) step();
        check_reset_values();
        rst = 1'b0;
        mon_en = 1'b1;

        throw_charge(40, 1'b0);            // dog: 10 ticks -> 160
        flight(0, 0, 1'b0, 1'b0);
        throw_charge(1600, 1'b0);          // cat: saturates at 1023
        flight(1, 0, 1'b0, 1'b0);          // hp_dog 3 -> 2
        throw_charge(12, 1'b0);            // dog: two hits, one counted
        flight(2, 0, 1'b0, 1'b0);
        throw_charge(7, 1'b0);             // cat: stray dog hit, hit with done
        flight(0, 1, 1'b1, 1'b0);
        throw_charge(9, 1'b1);             // dog: stray cat hit, timeout
        flight(0, 1, 1'b0, 1'b1);
        throw_charge(5, 1'b0);             // cat: final hit -> game over
        flight(1, 0, 1'b0, 1'b0);

        hit_by_cat = 1'b1; step(); hit_by_cat = 1'b0; step();
        check("hp_over", hp_dog, 0);
        check("over_hold", game_over, 1);

        btn_throw = 1'b1; step(); step();
        btn_throw = 1'b0;
        hpd_m = HPI; hpc_m = HPI; turn_m = 0;
        sq.push_back('{0, HPI, HPI, 0, -1});
        repeat (3) step();

        throw_charge(8, 1'b0);             // reset in mid-flight
        step();
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_same_cycle_en", enable_dog | enable_cat, 0);
        step();
        check_reset_values();
        rst = 1'b0;
        fq.delete();
        sq.delete();
        hpd_m = HPI; hpc_m = HPI; turn_m = 0;
        step();
        mon_en = 1'b1;

        throw_charge(1, 1'b0);             // shortest legal press
        flight(0, 0, 1'b0, 1'b0);

        check("fq_left", fq.size(), 0);
        check("sq_left", sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
